// File: rtl/avg_stream_driver_if.sv
// Engine-facing pins of the pair-average self-test: reset/data toward the engine,
// valid/result back from it.
interface avg_stream_driver_if;
   logic       dut_reset;
   logic [7:0] dut_data;
   logic       dut_valid;
   logic [7:0] dut_out;

   modport master (output dut_reset, output dut_data, input dut_valid, input dut_out);
   modport slave  (input dut_reset, input dut_data, output dut_valid, output dut_out);
endinterface

// File: rtl/avg_stream_driver.sv
// Self-test driver: resets the 8-tap pair-average engine, streams 128 LFSR bytes,
// then checks its 120 results in order and reports pass/fail, errors and timeout.
module avg_stream_driver #(
   parameter int TIMEOUT = 256
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [7:0]           seed,
   avg_stream_driver_if.master  eng,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic                 timeout,
   output logic [6:0]           err_count,
   output logic [6:0]           rx_count
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, DRST, SEND, RECV, DONE} state_t;

   state_t        state_q, state_d;
   logic          dut_reset_q, dut_reset_d;
   logic [7:0]    dut_data_q, dut_data_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          pass_q, pass_d;
   logic          timeout_q, timeout_d;
   logic [6:0]    err_count_q, err_count_d;
   logic [6:0]    rx_count_q, rx_count_d;
   logic [7:0]    lfsr_q, lfsr_d;
   logic [6:0]    idx_q, idx_d;
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

   logic [7:0]    mem [128];
   logic          mem_we;
   logic [6:0]    mem_wa;
   logic [7:0]    lfsr_next;
   logic [8:0]    pair_sum;
   logic [7:0]    exp_byte;
   logic          err_inc;
   logic          finish;

   always_comb begin
      state_d     = state_q;
      dut_reset_d = dut_reset_q;
      dut_data_d  = dut_data_q;
      busy_d      = busy_q;
      done_d      = done_q;
      pass_d      = pass_q;
      timeout_d   = timeout_q;
      err_count_d = err_count_q;
      rx_count_d  = rx_count_q;
      lfsr_d      = lfsr_q;
      idx_d       = idx_q;
      tmo_cnt_d   = tmo_cnt_q;
      mem_we      = 1'b0;
      mem_wa      = idx_q;
      err_inc     = 1'b0;
      finish      = 1'b0;

      lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      // Rounded average over a 9-bit sum; result r pairs sample r with sample r+8.
      pair_sum  = {1'b0, mem[rx_count_q]} + {1'b0, mem[rx_count_q + 7'd8]} + 9'd1;
      exp_byte  = 8'(pair_sum >> 1);

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d     = DRST;
               lfsr_d      = (seed == 8'h00) ? 8'h01 : seed;
               idx_d       = 7'd0;
               err_count_d = 7'd0;
               rx_count_d  = 7'd0;
               tmo_cnt_d   = '0;
               timeout_d   = 1'b0;
               done_d      = 1'b0;
               pass_d      = 1'b0;
               busy_d      = 1'b1;
               dut_reset_d = 1'b1;
            end
         end
         DRST: begin
            err_inc = eng.dut_valid;
            if (idx_q[0]) begin
               // Sample 0 goes out on the same edge that releases the engine reset.
               state_d     = SEND;
               dut_reset_d = 1'b0;
               dut_data_d  = lfsr_q;
               mem_we      = 1'b1;
               mem_wa      = 7'd0;
               lfsr_d      = lfsr_next;
               idx_d       = 7'd0;
            end else begin
               idx_d = 7'd1;
            end
         end
         SEND: begin
            err_inc = eng.dut_valid;
            if (idx_q == 7'd127) begin
               state_d    = RECV;
               dut_data_d = 8'h00;
               tmo_cnt_d  = '0;
            end else begin
               idx_d      = idx_q + 7'd1;
               dut_data_d = lfsr_q;
               mem_we     = 1'b1;
               mem_wa     = idx_q + 7'd1;
               lfsr_d     = lfsr_next;
            end
         end
         RECV: begin
            if (eng.dut_valid) begin
               tmo_cnt_d  = '0;
               rx_count_d = rx_count_q + 7'd1;
               err_inc    = (eng.dut_out != exp_byte);
               finish     = (rx_count_q == 7'd119);
            end else if (tmo_cnt_q == TMO_LAST) begin
               timeout_d = 1'b1;
               finish    = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (err_inc && err_count_q != 7'd127)
         err_count_d = err_count_q + 7'd1;

      if (finish) begin
         state_d     = DONE;
         busy_d      = 1'b0;
         done_d      = 1'b1;
         dut_reset_d = 1'b1;
         pass_d      = (err_count_d == 7'd0) && !timeout_d && (rx_count_d == 7'd120);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         dut_reset_q <= 1'b1;
         dut_data_q  <= 8'h00;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         timeout_q   <= 1'b0;
         err_count_q <= 7'd0;
         rx_count_q  <= 7'd0;
         lfsr_q      <= 8'h01;
         idx_q       <= 7'd0;
         tmo_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         dut_reset_q <= dut_reset_d;
         dut_data_q  <= dut_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         timeout_q   <= timeout_d;
         err_count_q <= err_count_d;
         rx_count_q  <= rx_count_d;
         lfsr_q      <= lfsr_d;
         idx_q       <= idx_d;
         tmo_cnt_q   <= tmo_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_wa] <= lfsr_q;
   end

   assign eng.dut_reset = dut_reset_q;
   assign eng.dut_data  = dut_data_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign timeout       = timeout_q;
   assign err_count     = err_count_q;
   assign rx_count      = rx_count_q;
endmodule

// File: tb/tb_avg_stream_driver.sv
// Bench for avg_stream_driver: an ideal/faulty engine stand-in plus a cycle-timeline
// reference model compared against every output on every falling edge.
module tb_avg_stream_driver;
   localparam int TIMEOUT = 256;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] seed;
   logic       busy, done, pass, timeout;
   logic [6:0] err_count, rx_count;

   avg_stream_driver_if eng_if ();

   avg_stream_driver #(.TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .seed      (seed),
      .eng       (eng_if),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .timeout   (timeout),
      .err_count (err_count),
      .rx_count  (rx_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, required %h", name, act, exp);
   endtask

   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   function automatic int avg2(input int a, input int b);
      return (a + b + 1) / 2;
   endfunction

   // Reference model: timeline position t counts edges since the accepted start.
   logic [7:0] m_samp [128];
   int  t = -1;
   bit  m_done = 0, m_tmo = 0;
   int  m_err = 0, m_rx = 0, m_idle = 0;
   bit  chk_en = 0;

   always @(posedge clk) begin
      if (reset) begin
         t = -1; m_done = 0; m_tmo = 0; m_err = 0; m_rx = 0; m_idle = 0;
      end else if ((t < 0 || m_done) && start) begin
         logic [7:0] v;
         v = (seed == 8'h00) ? 8'h01 : seed;
         for (int i = 0; i < 128; i++) begin
            m_samp[i] = v;
            v = lfsr_step(v);
         end
         t = 0; m_done = 0; m_tmo = 0; m_err = 0; m_rx = 0; m_idle = 0;
      end else if (t >= 0 && !m_done) begin
         if (t < 130) begin
            if (eng_if.dut_valid && m_err < 127) m_err++;
         end else if (eng_if.dut_valid) begin
            if (int'(eng_if.dut_out) != avg2(int'(m_samp[m_rx]), int'(m_samp[m_rx + 8])) && m_err < 127)
               m_err++;
            m_rx++;
            m_idle = 0;
            if (m_rx == 120) m_done = 1;
         end else begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
               m_tmo = 1; m_done = 1;
            end
         end
         t++;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic       e_busy, e_pass, e_drst;
         logic [7:0] e_data;
         e_busy = (t >= 0) && !m_done;
         e_pass = m_done && m_err == 0 && !m_tmo && m_rx == 120;
         e_drst = !((t >= 2) && !m_done);
         e_data = (t >= 2 && t <= 129 && !m_done) ? m_samp[t - 2] : 8'h00;
         check("cycle{busy,done,pass,tmo,drst,data,err,rx}",
               32'({busy, done, pass, timeout, eng_if.dut_reset, eng_if.dut_data, err_count, rx_count}),
               32'({e_busy, m_done, e_pass, m_tmo, e_drst, e_data, 7'(m_err), 7'(m_rx)}));
      end
   end

   // Engine stand-in: captures bytes while out of reset.
   logic [7:0] cap [$];
   always @(posedge clk) begin
      if (reset || eng_if.dut_reset) cap.delete();
      else if (cap.size() < 128) cap.push_back(eng_if.dut_data);
   end

   task automatic do_start(input logic [7:0] s);
      @(negedge clk);
      seed  = s;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_engine(input bit corrupt, input int long_gap_at);
      int w = 0;
      while (cap.size() < 128 && w < 400) begin
         @(negedge clk);
         w++;
      end
      check("engine_capture_count", 32'(cap.size()), 32'd128);
      for (int j = 0; j < 120; j++) begin
         int gap;
         logic [7:0] rb;
         gap = (j == long_gap_at) ? TIMEOUT - 1 : int'($urandom_range(0, 3));
         eng_if.dut_valid = 1'b0;
         repeat (gap) @(negedge clk);
         rb = 8'(avg2(int'(cap[j]), int'(cap[j + 8])));
         if (corrupt && (j == 0 || j == 50 || j == 119)) rb = rb ^ 8'h01;
         eng_if.dut_valid = 1'b1;
         eng_if.dut_out   = rb;
         @(negedge clk);
      end
      eng_if.dut_valid = 1'b0;
      eng_if.dut_out   = 8'h00;
   endtask

   task automatic wait_done(input int limit, output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < limit) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic end_checks(input string tag, input int e_err, input bit e_pass,
                             input int e_rx, input bit e_tmo);
      check({tag, "_done"},    32'(done),      32'd1);
      check({tag, "_err"},     32'(err_count), 32'(e_err));
      check({tag, "_pass"},    32'(pass),      32'(e_pass));
      check({tag, "_rx"},      32'(rx_count),  32'(e_rx));
      check({tag, "_timeout"}, 32'(timeout),   32'(e_tmo));
      check({tag, "_busy"},    32'(busy),      32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] lit [9];
      int cyc;
      lit = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E, 8'h1C};
      reset = 1'b1; start = 1'b0; seed = 8'h00;
      eng_if.dut_valid = 1'b0; eng_if.dut_out = 8'h00;
      repeat (3) @(negedge clk);
      chk_en = 1;
      check("reset_dut_reset", 32'(eng_if.dut_reset), 32'd1);
      check("reset_busy",      32'(busy),             32'd0);
      check("reset_done",      32'(done),             32'd0);
      check("reset_err",       32'(err_count),        32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Seed 01, ideal engine; pin the stream and first average literally.
      do_start(8'h01);
      check("drst_hold", 32'(eng_if.dut_reset), 32'd1);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 9; i++) begin
         check("seed01_stream", 32'(eng_if.dut_data), 32'(lit[i]));
         check("model_stream", 32'(m_samp[i]), 32'(lit[i]));
         @(negedge clk);
      end
      check("model_first_avg", 32'(avg2(int'(m_samp[0]), int'(m_samp[8]))), 32'h0F);
      run_engine(1'b0, -1);
      wait_done(20, cyc);
      check("done_latency", 32'(cyc), 32'd0);
      end_checks("seed01", 0, 1'b1, 120, 1'b0);
      repeat (3) @(negedge clk);

      // Seed 00 behaves as 01; start mid-run ignored; longest legal gap.
      do_start(8'h00);
      repeat (2) @(negedge clk);
      check("seed00_first", 32'(eng_if.dut_data), 32'h01);
      repeat (48) @(negedge clk);
      start = 1'b1; seed = 8'h55;
      @(negedge clk);
      start = 1'b0;
      run_engine(1'b0, 10);
      wait_done(20, cyc);
      end_checks("seed00", 0, 1'b1, 120, 1'b0);
      repeat (3) @(negedge clk);

      // Corrupted results 0, 50, 119.
      do_start(8'($urandom_range(1, 255)));
      run_engine(1'b1, -1);
      wait_done(20, cyc);
      end_checks("corrupt", 3, 1'b0, 120, 1'b0);
      repeat (3) @(negedge clk);

      // Engine never answers.
      do_start(8'($urandom_range(0, 255)));
      wait_done(130 + TIMEOUT + 40, cyc);
      check("timeout_latency", 32'(cyc), 32'(130 + TIMEOUT));
      end_checks("timeout", 0, 1'b0, 0, 1'b1);
      repeat (3) @(negedge clk);

      // Spurious valid during SEND.
      do_start(8'($urandom_range(0, 255)));
      repeat (40) @(negedge clk);
      eng_if.dut_valid = 1'b1;
      eng_if.dut_out   = 8'h00;
      @(negedge clk);
      eng_if.dut_valid = 1'b0;
      run_engine(1'b0, -1);
      wait_done(20, cyc);
      end_checks("proto", 1, 1'b0, 120, 1'b0);
      repeat (3) @(negedge clk);

      // Reset while sample 60 is on the bus, then a clean run.
      do_start(8'h01);
      repeat (62) @(negedge clk);
      check("abort_sample60", 32'(eng_if.dut_data), 32'(m_samp[60]));
      reset = 1'b1;
      @(negedge clk);
      check("abort_dut_reset", 32'(eng_if.dut_reset), 32'd1);
      check("abort_busy",      32'(busy),             32'd0);
      check("abort_data",      32'(eng_if.dut_data),  32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      do_start(8'h01);
      run_engine(1'b0, -1);
      wait_done(20, cyc);
      end_checks("after_abort", 0, 1'b1, 120, 1'b0);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
